match_result_uart_tx: RTL
=========================

# match_result_uart_tx

Downstream stage of the template-matching top level: consumes the `valid` / `x_out` / `y_out` result and the no-match indication and serializes them as an 8N1 UART byte stream on `tx`. When the report is fully shifted out it returns the `UARTsendComplete` handshake that the control unit waits on. It runs on the single system clock and holds each transfer stable internally, so the result registers upstream may change once a send has started.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `valid`  in  1  level request: match found, send the coordinate packet.
- `no_match`  in  1  level request: search finished without a match, send the no-match packet.
- `x_in`  in  10  match column, sampled when a match send is accepted.
- `y_in`  in  9  match row, sampled when a match send is accepted.
- `tx`  out  1  UART serial line, idle high.
- `busy`  out  1  high from acceptance until `UARTsendComplete` is pulsed.
- `UARTsendComplete`  out  1  one-cycle pulse after the final stop bit of a packet.

## Operation
- Packets, bytes sent in order, each 8N1 LSB first:
  - match (5 bytes): 0x4D ('M'), {6'b0, x[9:8]}, x[7:0], {7'b0, y[8]}, y[7:0].
  - no-match (1 byte): 0x4E ('N').
- Acceptance: only in IDLE with `armed`=1. If `valid`=1, the block latches `x_in`/`y_in` and the match packet; else if `no_match`=1, it latches the no-match packet. `valid` wins when both are high.
- Re-arm: after a packet, `armed` clears and sets only once a cycle is seen with `valid`=0 and `no_match`=0. A level request still held after completion is therefore never sent twice.
- FSM states: IDLE → START (tx=0) → DATA (8 bits, bit index 0..7) → STOP (tx=1). From STOP:
  - more bytes remain → next byte index → START;
  - otherwise → DONE.
- DONE lasts one cycle: pulses `UARTsendComplete`, then → IDLE.
- Counters:
  - baud counter 0..CLKS_PER_BIT-1 (width clog2(CLKS_PER_BIT));
  - bit index 3 bits;
  - byte index 3 bits, 0..4.
- Byte and bit indices advance only when the baud counter reaches CLKS_PER_BIT-1, after which the counter wraps to 0.
- Requests arriving while `busy` are ignored; they do not queue.
- `x_in`/`y_in` changes after acceptance have no effect on the packet.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `UARTsendComplete`=0, `armed`=1;
  - state IDLE, all counters 0, latched payload 0.
- Asserting `reset` mid-frame forces `tx` high asynchronously and aborts the packet; no `UARTsendComplete` is issued.
- Acceptance to start bit: request sampled high at edge N → `busy`=1 and `tx`=0 from edge N (registered outputs).
- Each bit holds exactly CLKS_PER_BIT cycles. Bytes are back-to-back with no idle gap.
- Match packet: 50·CLKS_PER_BIT cycles of line activity. No-match packet: 10·CLKS_PER_BIT cycles.
- `UARTsendComplete`: high for the single cycle starting at the edge that ends the last stop bit. `busy` falls on the following edge.
- Earliest next acceptance: the cycle after a request-low cycle is observed in IDLE.
- `tx`, `busy` and `UARTsendComplete` are registered and glitch-free.

## Test plan
- Reset: hold `reset`=0 for 5 cycles with `valid`=1 → `tx`=1, `busy`=0, no start bit; release → start bit on the first edge.
- Match send (CLKS_PER_BIT=4): `valid`=1, x=10'h2A5, y=9'h1C3 → bytes 0x4D, 0x02, 0xA5, 0x01, 0xC3 decoded by the bench UART model. Line activity is 200 cycles, followed by one `UARTsendComplete` pulse.
- No-match send: `no_match`=1 → single byte 0x4E, 40 cycles, one completion pulse. Hold `no_match` high for 100 cycles afterward → no second packet.
- Priority and latching:
  - `valid`=`no_match`=1 → 'M' packet only;
  - change `x_in` to 0 mid-packet → transmitted x bytes unchanged.
- Busy ignore and re-arm:
  - pulse `no_match` during a match send → no extra packet;
  - drop `valid` for 1 cycle after completion, then raise it → exactly one new packet.
- Mid-frame reset: assert `reset` during byte 2, data bit 3 → `tx`=1 in the same cycle, no completion pulse. After release with `valid`=1, a full fresh 5-byte packet is sent.

Source files
------------

// File: rtl/match_result_uart_tx.sv
// Serializes a template-match result (or a no-match indication) as an 8N1 UART packet and
// pulses UARTsendComplete once the final stop bit has left the line.
module match_result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic       no_match,
    input  logic [9:0] x_in,
    input  logic [8:0] y_in,
    output logic       tx,
    output logic       busy,
    output logic       UARTsendComplete
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic              is_match_q, is_match_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic              armed_q, armed_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0]        cur_byte;
    logic [2:0]        last_byte;
    logic              baud_tick;

    assign baud_tick = (baud_q == BaudMax);
    assign last_byte = is_match_q ? 3'd4 : 3'd0;

    always_comb begin
        case (byte_q)
            3'd0:    cur_byte = is_match_q ? 8'h4D : 8'h4E;
            3'd1:    cur_byte = {6'b0, x_q[9:8]};
            3'd2:    cur_byte = x_q[7:0];
            3'd3:    cur_byte = {7'b0, y_q[8]};
            default: cur_byte = y_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        is_match_d = is_match_q;
        x_d        = x_q;
        y_d        = y_q;
        armed_d    = armed_q;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                if (armed_q && (valid || no_match)) begin
                    state_d    = StStart;
                    armed_d    = 1'b0;
                    is_match_d = valid;
                    if (valid) begin
                        x_d = x_in;
                        y_d = y_in;
                    end
                end else if (!valid && !no_match) begin
                    // Re-arm only on a request-low cycle so a held level is sent once.
                    armed_d = 1'b1;
                end
            end
            StStart: begin
                baud_d = baud_tick ? '0 : baud_q + 1'b1;
                if (baud_tick) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                baud_d = baud_tick ? '0 : baud_q + 1'b1;
                if (baud_tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                baud_d = baud_tick ? '0 : baud_q + 1'b1;
                if (baud_tick) begin
                    if (byte_q == last_byte) begin
                        state_d = StDone;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = StStart;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they register on the same edge.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            is_match_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            armed_q    <= 1'b1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            is_match_q <= is_match_d;
            x_q        <= x_d;
            y_q        <= y_d;
            armed_q    <= armed_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx               = tx_q;
    assign busy             = busy_q;
    assign UARTsendComplete = done_q;

endmodule
